// File: rtl/walk_request_bank.sv
// Crosswalk walk-request bank: per-channel sync, debounce, request latch and wait age,
// plus a pending summary and lowest-index pending channel for the light sequencer.

module walk_request_lane #(
    parameter int DEB_CYC = 8,
    parameter int AGE_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_btn,
    input  logic             i_grant,
    input  logic             i_en,
    output logic             o_req,
    output logic [AGE_W-1:0] o_age
);
    localparam int CNT_W = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(DEB_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_req;
    logic [AGE_W-1:0] r_age;
    logic             w_hit;

    // Counter saturates at DEB_CYC, so a held button crosses the hit value only once.
    assign w_hit = r_sync2 && (r_cnt == CNT_HIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= w_hit;
            if (!r_sync2)
                r_cnt <= '0;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Grant beats a coincident press; age starts at 0 on the set edge since r_req was 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req <= 1'b0;
            r_age <= '0;
        end else begin
            if (i_grant)
                r_req <= 1'b0;
            else if (r_press && i_en)
                r_req <= 1'b1;

            if (!r_req || i_grant)
                r_age <= '0;
            else if (r_age != '1)
                r_age <= r_age + 1'b1;
        end
    end

    assign o_req = r_req;
    assign o_age = r_age;
endmodule

module walk_request_bank #(
    parameter int N_CH    = 4,
    parameter int DEB_CYC = 8,
    parameter int AGE_W   = 8,
    localparam int FW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  WRB_Clk,
    input  logic                  WRB_Reset_n,
    input  logic [N_CH-1:0]       WRB_Button,
    input  logic [N_CH-1:0]       WRB_Grant,
    input  logic                  WRB_Enable,
    output logic [N_CH-1:0]       WRB_Req,
    output logic                  WRB_Any,
    output logic [FW-1:0]         WRB_First,
    output logic [N_CH*AGE_W-1:0] WRB_Age
);
    logic [N_CH-1:0]            w_req;
    logic [N_CH-1:0][AGE_W-1:0] w_age;
    logic [FW-1:0]              w_first;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        walk_request_lane #(
            .DEB_CYC (DEB_CYC),
            .AGE_W   (AGE_W)
        ) u_lane (
            .i_clk   (WRB_Clk),
            .i_rst_n (WRB_Reset_n),
            .i_btn   (WRB_Button[g]),
            .i_grant (WRB_Grant[g]),
            .i_en    (WRB_Enable),
            .o_req   (w_req[g]),
            .o_age   (w_age[g])
        );
    end

    // Scan high-to-low so the lowest pending index is the last one written.
    always_comb begin
        w_first = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (w_req[i])
                w_first = FW'(i);
    end

    assign WRB_Req   = w_req;
    assign WRB_Any   = |w_req;
    assign WRB_First = w_first;
    assign WRB_Age   = w_age;
endmodule

// File: tb/tb_walk_request_bank.sv
// Bench for walk_request_bank: table of press vectors plus hand-built timing sequences,
// expectations queued with a due cycle and compared by a scoreboard process.

module tb_walk_request_bank;
    localparam int N  = 4;
    localparam int DB = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  btn = '0;
    logic [N-1:0]  grant = '0;
    logic          en = 1'b1;
    logic [N-1:0]  req;
    logic          any;
    logic [1:0]    first;
    logic [N*AW-1:0] age;

    walk_request_bank #(.N_CH(N), .DEB_CYC(DB), .AGE_W(AW)) dut (
        .WRB_Clk     (clk),
        .WRB_Reset_n (rst_n),
        .WRB_Button  (btn),
        .WRB_Grant   (grant),
        .WRB_Enable  (en),
        .WRB_Req     (req),
        .WRB_Any     (any),
        .WRB_First   (first),
        .WRB_Age     (age)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_run = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        int         due;
        logic [3:0] req;
        logic [1:0] first;
        logic       any;
        int         ach;
        logic [3:0] aval;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        string      name;
        logic [3:0] btn;
        int         hold;
        logic       en;
        logic [3:0] req;
        logic [1:0] first;
    } vec_t;

    vec_t vecs[8];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int n, input string name, input logic [3:0] r,
                        input logic [1:0] f, input int ach = -1, input logic [3:0] av = 4'd0);
        exp_t e;
        e.name = name; e.due = cyc + n; e.req = r; e.first = f;
        e.any = |r; e.ach = ach; e.aval = av;
        sb.push_back(e);
    endtask

    function automatic int cmp(input exp_t e);
        logic [3:0] a_act;
        bit bad;
        a_act = (e.ach >= 0) ? age[e.ach*AW +: AW] : 4'd0;
        bad = (req !== e.req) || (first !== e.first) || (any !== e.any) ||
              ((e.ach >= 0) && (a_act !== e.aval));
        if (bad)
            $display("FAIL %s: got req=%b first=%0d any=%b age=%0d, want req=%b first=%0d any=%b age=%0d",
                     e.name, req, first, any, a_act, e.req, e.first, e.any, e.aval);
        return bad ? 1 : 0;
    endfunction

    task automatic chk_now(input string name, input logic [3:0] r, input logic [1:0] f,
                           input int ach, input logic [3:0] av);
        exp_t e;
        e.name = name; e.due = cyc; e.req = r; e.first = f;
        e.any = |r; e.ach = ach; e.aval = av;
        n_run++;
        n_fail += cmp(e);
    endtask

    // Scoreboard: compare every queued expectation whose due edge has just passed.
    always begin : sb_check
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_run++;
            if (e.due < cyc) begin
                $display("FAIL %s: checked at cycle %0d, want cycle %0d", e.name, cyc, e.due);
                n_fail++;
            end else begin
                n_fail += cmp(e);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() > 0; i++) step(1);
        if (sb.size() > 0) begin
            n_run++;
            n_fail++;
            $display("FAIL drain: %0d expectations pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic clean();
        drain();
        btn = '0;
        en = 1'b1;
        grant = 4'hF;
        step(1);
        grant = '0;
        step(4);
    endtask

    initial begin
        vecs[0] = '{"t_ch2_20",  4'b0100, 20, 1'b1, 4'b0100, 2'd2};
        vecs[1] = '{"t_glitch5", 4'b0001,  5, 1'b1, 4'b0000, 2'd0};
        vecs[2] = '{"t_edge7",   4'b0001,  7, 1'b1, 4'b0000, 2'd0};
        vecs[3] = '{"t_edge8",   4'b0001,  8, 1'b1, 4'b0001, 2'd0};
        vecs[4] = '{"t_pair",    4'b1010, 12, 1'b1, 4'b1010, 2'd1};
        vecs[5] = '{"t_all_dis", 4'b1111, 12, 1'b0, 4'b0000, 2'd0};
        vecs[6] = '{"t_all",     4'b1111, 10, 1'b1, 4'b1111, 2'd0};
        vecs[7] = '{"t_ch3_9",   4'b1000,  9, 1'b1, 4'b1000, 2'd3};

        // reset state
        step(2);
        chk_now("reset_state", 4'b0000, 2'd0, 2, 4'd0);
        rst_n = 1'b1;
        step(2);

        foreach (vecs[i]) begin
            clean();
            en  = vecs[i].en;
            btn = vecs[i].btn;
            push(vecs[i].hold + 6, vecs[i].name, vecs[i].req, vecs[i].first);
            step(vecs[i].hold);
            btn = '0;
            step(8);
            en = 1'b1;
        end

        // exact latency, age, single set for a held button
        clean();
        btn = 4'b0100;
        push(10, "lat_pre", 4'b0000, 2'd0);
        push(11, "lat_set", 4'b0100, 2'd2, 2, 4'd0);
        push(14, "lat_age3", 4'b0100, 2'd2, 2, 4'd3);
        step(20);
        push(1, "lat_age10", 4'b0100, 2'd2, 2, 4'd10);
        step(1);
        grant = 4'b0100;
        push(1, "lat_grant", 4'b0000, 2'd0, 2, 4'd0);
        step(1);
        grant = '0;
        push(5, "lat_no_relatch", 4'b0000, 2'd0);
        step(5);
        btn = '0;
        step(2);

        // long hold, grant, release, re-press
        clean();
        btn = 4'b0001;
        push(11, "c_set", 4'b0001, 2'd0);
        step(30);
        btn = '0;
        grant = 4'b0001;
        push(1, "c_clr", 4'b0000, 2'd0);
        step(1);
        grant = '0;
        step(3);
        btn = 4'b0001;
        push(11, "c_repress", 4'b0001, 2'd0);
        step(12);
        btn = '0;
        step(2);

        // priority and summary
        clean();
        btn = 4'b1000;
        push(12, "d_ch3", 4'b1000, 2'd3);
        push(16, "d_both", 4'b1010, 2'd1);
        step(4);
        btn = 4'b1010;
        step(16);
        btn = '0;
        grant = 4'b0010;
        push(1, "d_grant1", 4'b1000, 2'd3);
        step(1);
        grant = 4'b1000;
        push(1, "d_grant3", 4'b0000, 2'd0);
        step(1);
        grant = '0;
        step(1);

        // press pulse and grant on the same edge
        clean();
        btn = 4'b0001;
        step(10);
        grant = 4'b0001;
        push(1, "e_collide", 4'b0000, 2'd0);
        step(1);
        grant = '0;
        push(3, "e_lost", 4'b0000, 2'd0);
        step(3);
        btn = '0;
        step(3);

        // disabled press is dropped, not deferred
        clean();
        en = 1'b0;
        btn = 4'b0100;
        step(14);
        en = 1'b1;
        push(4, "f_nodefer", 4'b0000, 2'd0);
        step(4);
        btn = '0;
        step(2);

        // age count, no restart on re-press, saturation, clear
        clean();
        btn = 4'b0010;
        push(11, "g_age0", 4'b0010, 2'd1, 1, 4'd0);
        push(12, "g_age1", 4'b0010, 2'd1, 1, 4'd1);
        push(24, "g_norestart", 4'b0010, 2'd1, 1, 4'd13);
        push(26, "g_sat15", 4'b0010, 2'd1, 1, 4'd15);
        push(51, "g_hold15", 4'b0010, 2'd1, 1, 4'd15);
        step(8);
        btn = '0;
        step(4);
        btn = 4'b0010;
        step(12);
        btn = '0;
        step(42);
        grant = 4'b0010;
        push(1, "g_clr", 4'b0000, 2'd0, 1, 4'd0);
        step(1);
        grant = '0;
        step(1);

        // reset mid-debounce with a request latched; button held through release
        clean();
        btn = 4'b0010;
        push(11, "h_set", 4'b0010, 2'd1);
        step(14);
        btn = 4'b0100;
        step(5);
        drain();
        #3 rst_n = 1'b0;
        #1 chk_now("h_rst_now", 4'b0000, 2'd0, 1, 4'd0);
        step(2);
        chk_now("h_rst_hold", 4'b0000, 2'd0, 1, 4'd0);
        rst_n = 1'b1;
        push(10, "h_pre", 4'b0000, 2'd0);
        push(11, "h_held", 4'b0100, 2'd2, 1, 4'd0);
        step(12);
        btn = '0;
        step(2);

        drain();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/walk_request_bank.md
# walk_request_bank

Multi-channel pedestrian walk-request register for the traffic light controller. Each channel synchronises a raw push-button input, debounces it, latches a request on a qualified press, and holds it until the controller's sequencer grants that crossing. It also reports a pending summary, the lowest-index pending channel and a per-channel saturating wait age. It sits between the crosswalk button pads and the main light-sequencing state machine.

## Interface
- N_CH, 4: number of crosswalk channels (1..16)
- DEB_CYC, 8: cycles the synchronised button must stay high to qualify a press (≥1)
- AGE_W, 8: width of each per-channel wait-age counter
- WRB_Clk  input  1  system clock; all state on rising edge
- WRB_Reset_n  input  1  asynchronous active-low reset
- WRB_Button  input  N_CH  raw asynchronous button levels, 1 = pressed
- WRB_Grant  input  N_CH  one-cycle clear pulses from the sequencer, one bit per channel
- WRB_Enable  input  1  1 = accept new presses; 0 = ignore presses, keep latched requests
- WRB_Req  output  N_CH  latched walk request per channel
- WRB_Any  output  1  OR of WRB_Req
- WRB_First  output  clog2(N_CH) (min 1)  index of the lowest-numbered set WRB_Req bit; 0 when none
- WRB_Age  output  N_CH*AGE_W  per-channel cycles-since-latch, channel i at bits [i*AGE_W +: AGE_W]

## Operation
- Per channel, independent pipeline: 2-flop synchroniser -> debounce counter -> press qualifier -> request latch -> age counter.
- Debounce counter: counts up while synchronised level is 1, resets to 0 when level is 0; saturates at DEB_CYC. Qualified press = one-cycle pulse on the cycle the counter reaches DEB_CYC. A held button produces exactly one pulse; the button must release (synchronised 0) before another press can qualify.
- Request latch: set on qualified press when WRB_Enable = 1; cleared by WRB_Grant bit. Press pulse while WRB_Enable = 0 is discarded (not deferred).
- Simultaneous press pulse and grant on the same channel in the same cycle: grant wins, WRB_Req goes to 0, press is lost.
- Press while WRB_Req already 1: no effect; age is not restarted.
- Grant while WRB_Req = 0: no effect.
- Age counter: 0 while WRB_Req = 0; loads 0 on the set cycle, then +1 each cycle while WRB_Req = 1; saturates at 2^AGE_W - 1 (no wrap). Cleared to 0 with the request.
- WRB_Any, WRB_First: combinational from registered WRB_Req.
- Reset (any time, including mid-debounce or with requests latched): all synchroniser flops, debounce counters, WRB_Req and ages go to 0 immediately; WRB_Any = 0, WRB_First = 0. Button held across reset release must be released and re-pressed to qualify... no: a button held through reset release counts up from 0 and qualifies after sync + DEB_CYC cycles like a new press.

## Timing
- Button rise to WRB_Req = 1: 2 (sync) + DEB_CYC cycles, with WRB_Req visible on the following edge; i.e. button sampled high at edge k, WRB_Req high after edge k+2+DEB_CYC.
- Glitch shorter than DEB_CYC synchronised cycles: no request.
- Grant at edge k: WRB_Req and age are 0 after edge k; WRB_Any/WRB_First update in the same cycle.
- Age after set edge s reads n at edge s+n until saturation.
- No ready/valid handshake; grant is a single-cycle pulse and multi-cycle grants behave as repeated clears.

## Test plan
- Reset: assert WRB_Reset_n low mid-debounce with ch1 latched -> all outputs 0 immediately, no request after release unless button re-qualifies.
- Single press, DEB_CYC=8: ch2 high 20 cycles -> WRB_Req=4'b0100 exactly 10 cycles after first sampled high, WRB_First=2, one set only.
- Glitch: ch0 high 5 cycles -> WRB_Req stays 0; held high 30 cycles then released and re-pressed after grant -> second request latched.
- Priority/summary: latch ch3 then ch1 -> WRB_First=1; grant ch1 -> WRB_First=3; grant ch3 -> WRB_Any=0.
- Simultaneous press-qualify and grant on ch0 same cycle -> WRB_Req[0]=0; press with WRB_Enable=0 -> ignored.
- Age, AGE_W=4: hold request 40 cycles -> age counts 0..15 and stays 15; grant -> age 0.
